dut_emulator: RTL and testbench

DUT_EMULATOR -- requirements
Module: dut_emulator

---
 rtl/dut_emulator_pkg.sv | 28 ++
 rtl/dut_emulator_cmd_fifo.sv | 58 +++++
 rtl/dut_emulator.sv | 121 ++++++++++++
 tb/tb_dut_emulator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dut_emulator_pkg.sv
// rtl/dut_emulator_pkg.sv - shared constants for the emulated DUT and its tester
package dut_emulator_pkg;

  localparam int CMD_W = 16;

  // FSM encoding kept as plain vectors so older tooling can read the state bus
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [CMD_W-1:0] RESP_INV_MASK = 16'hFFFF;
  localparam logic [CMD_W-1:0] ERR_INJ_MASK  = 16'h0001;

  // tester pattern words
  localparam logic [CMD_W-1:0] PAT_ALT_A  = 16'hAAAA;
  localparam logic [CMD_W-1:0] PAT_ALT_5  = 16'h5555;
  localparam logic [CMD_W-1:0] PAT_ZEROS  = 16'h0000;
  localparam logic [CMD_W-1:0] PAT_ONES   = 16'hFFFF;

  function automatic logic [CMD_W-1:0] make_resp(input logic [CMD_W-1:0] cmd,
                                                 input logic err);
    logic [CMD_W-1:0] r;
    r = cmd ^ RESP_INV_MASK;
    if (err) r = r ^ ERR_INJ_MASK;
    return r;
  endfunction

endpackage

// File: rtl/dut_emulator_cmd_fifo.sv
// rtl/dut_emulator_cmd_fifo.sv - pending-command queue with registered full/empty
module cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
  logic             do_wr, do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_wr};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_rd};
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end
  end

  // flags are computed from the next pointers so they are exact in the cycle after the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dut_emulator.sv
// rtl/dut_emulator.sv - emulated DUT answering tester commands after a fixed latency
module dut_emulator
  import dut_emulator_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             power_en,
  input  logic [CMD_W-1:0] dac_cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             inject_err,
  output logic [CMD_W-1:0] adc_data,
  output logic             adc_ready,
  output logic [15:0]      resp_count,
  output logic             overflow
);

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  logic [1:0]       state;
  logic [7:0]       countdown;
  logic [CMD_W-1:0] cmd_q;
  logic             err_q;
  logic             pwr_q;
  logic             fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_rd_data;
  logic             push, pop;

  // both terms are registered: low in the cycle after the queue fills or power drops
  assign cmd_ready = pwr_q && !fifo_full;
  assign push      = power_en && cmd_valid && cmd_ready;

  always_comb begin
    pop = 1'b0;
    if (power_en && !fifo_empty && (state == ST_IDLE || state == ST_RESP)) pop = 1'b1;
  end

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (!power_en),
    .wr_en   (push),
    .wr_data (dac_cmd),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pwr_q <= power_en;
      if (power_en && cmd_valid && !cmd_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      countdown  <= 8'd0;
      cmd_q      <= '0;
      err_q      <= 1'b0;
      adc_data   <= '0;
      adc_ready  <= 1'b0;
      resp_count <= 16'd0;
    end else if (!power_en) begin
      // power loss drops the in-flight command silently; counters survive
      state     <= ST_IDLE;
      countdown <= 8'd0;
      adc_data  <= '0;
      adc_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          adc_ready <= 1'b0;
          if (pop) begin
            cmd_q     <= fifo_rd_data;
            err_q     <= inject_err;
            countdown <= CNT_LOAD;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (countdown == 8'd0) begin
            state     <= ST_RESP;
            adc_ready <= 1'b1;
            adc_data  <= make_resp(cmd_q, err_q);
            if (resp_count != 16'hFFFF) resp_count <= resp_count + 16'd1;
          end else begin
            countdown <= countdown - 8'd1;
          end
        end
        ST_RESP: begin
          adc_ready <= 1'b0;
          if (pop) begin
            cmd_q     <= fifo_rd_data;
            err_q     <= inject_err;
            countdown <= CNT_LOAD;
            state     <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          adc_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dut_emulator.sv
// tb/tb_dut_emulator.sv - randomized self-checking bench for dut_emulator
module tb_dut_emulator;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        power_en = 1'b0;
  logic [15:0] dac_cmd = 16'h0;
  logic        cmd_valid = 1'b0;
  logic        inject_err = 1'b0;
  logic        cmd_ready;
  logic [15:0] adc_data;
  logic        adc_ready;
  logic [15:0] resp_count;
  logic        overflow;

  dut_emulator #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .power_en   (power_en),
    .dac_cmd    (dac_cmd),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .inject_err (inject_err),
    .adc_data   (adc_data),
    .adc_ready  (adc_ready),
    .resp_count (resp_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: each accepted command is scheduled with a dequeue edge and response edge
  typedef struct { logic [15:0] cmd; logic err; int d; int r; } job_t;
  typedef struct { int cyc; logic [15:0] data; } cap_t;

  job_t        jobs[$];
  cap_t        caps[$];
  int          cyc = 0;
  int          free_edge = 0;
  logic        m_ready, m_ovf, m_adc_ready;
  logic [15:0] m_data, m_cnt;
  bit          saw_busy;

  task automatic model_reset();
    jobs.delete();
    free_edge   = 0;
    m_ready     = 1'b0;
    m_ovf       = 1'b0;
    m_adc_ready = 1'b0;
    m_data      = 16'h0;
    m_cnt       = 16'h0;
  endtask

  task automatic model_edge(input logic p, input logic v, input logic [15:0] c, input logic e);
    int occ;
    int d;
    cyc++;
    m_adc_ready = 1'b0;
    if (!p) begin
      jobs.delete();
      m_data    = 16'h0;
      free_edge = 0;
      m_ready   = 1'b0;
      return;
    end
    if (v && !m_ready) m_ovf = 1'b1;
    if (v && m_ready) begin
      d = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
      jobs.push_back('{c, 1'b0, d, d + LAT});
      free_edge = d + LAT + 1;
    end
    foreach (jobs[i]) if (jobs[i].d == cyc) jobs[i].err = e;
    if (jobs.size() > 0 && jobs[0].r == cyc) begin
      m_adc_ready = 1'b1;
      m_data = ~jobs[0].cmd ^ (jobs[0].err ? 16'h0001 : 16'h0000);
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      void'(jobs.pop_front());
    end
    occ = 0;
    foreach (jobs[i]) if (jobs[i].d > cyc) occ++;
    m_ready = (occ < DEPTH);
  endtask

  task automatic step(input logic p, input logic v, input logic [15:0] c, input logic e);
    power_en   = p;
    cmd_valid  = v;
    dac_cmd    = c;
    inject_err = e;
    @(posedge clk);
    model_edge(p, v, c, e);
    @(negedge clk);
    check_eq("adc_ready", adc_ready, m_adc_ready);
    check_eq("adc_data", adc_data, m_data);
    check_eq("cmd_ready", cmd_ready, m_ready);
    check_eq("overflow", overflow, m_ovf);
    check_eq("resp_count", resp_count, m_cnt);
    if (adc_ready) caps.push_back('{cyc, adc_data});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic push_cmd(input logic [15:0] c, input logic e);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      if (cmd_ready) begin
        step(1'b1, 1'b1, c, e);
        done = 1'b1;
      end else begin
        saw_busy = 1'b1;
        step(1'b1, 1'b0, 16'h0, 1'b0);
      end
    end
    check_eq("push_accept", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_adc_ready"}, adc_ready, 0);
    check_eq({tag, "_adc_data"}, adc_data, 0);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 0);
    check_eq({tag, "_resp_count"}, resp_count, 0);
    check_eq({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    power_en  = 1'b0;
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int acc;

  initial begin
    model_reset();

    // single command, then the same with error injected at dequeue
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0);
    caps.delete();
    step(1'b1, 1'b1, 16'hAAAA, 1'b0);
    acc = cyc;
    idle(8);
    check_eq("single_n", caps.size(), 1);
    if (caps.size() > 0) begin
      check_eq("single_lat", caps[0].cyc - acc, LAT + 1);
      check_eq("single_data", caps[0].data, 16'h5555);
    end
    check_eq("single_cnt", resp_count, 1);

    caps.delete();
    step(1'b1, 1'b1, 16'hAAAA, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    idle(7);
    check_eq("err_n", caps.size(), 1);
    if (caps.size() > 0) check_eq("err_data", caps[0].data, 16'h5554);

    // burst of six offered only when ready
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0);
    caps.delete();
    saw_busy = 1'b0;
    for (int k = 0; k < 6; k++) push_cmd(16'(k), 1'b0);
    idle(40);
    check_eq("burst_n", caps.size(), 6);
    check_eq("burst_busy", saw_busy, 1);
    check_eq("burst_ovf", overflow, 0);
    foreach (caps[i]) begin
      check_eq("burst_data", caps[i].data, 16'hFFFF - 16'(i));
      if (i > 0) check_eq("burst_gap", caps[i].cyc - caps[i-1].cyc, LAT + 1);
    end

    // valid held against a full queue
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 16'($urandom), 1'b0);
    idle(60);
    check_eq("ovf_sticky", overflow, 1);
    check_eq("ovf_ready_after", cmd_ready, 1);

    // power drop while commands are pending
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) push_cmd(16'h1000 + 16'(k), 1'b0);
    idle(2);
    caps.delete();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      check_eq("pwr_cmd_ready", cmd_ready, 0);
      check_eq("pwr_adc_data", adc_data, 0);
    end
    check_eq("pwr_no_resp", caps.size(), 0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    push_cmd(16'h1234, 1'b0);
    idle(10);
    check_eq("pwr_resume_n", caps.size(), 1);
    if (caps.size() > 0) check_eq("pwr_resume_data", caps[0].data, 16'hEDCB);

    // reset in the middle of WAIT
    push_cmd(16'h0F0F, 1'b0);
    idle(2);
    do_reset();
    caps.delete();
    idle(12);
    check_eq("rst_no_resp", caps.size(), 0);

    // random traffic with occasional power drops and error injection
    do_reset();
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 19) != 0, $urandom_range(0, 1) == 1,
           16'($urandom), $urandom_range(0, 1) == 1);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
